// File: rtl/alu_child_pkg.sv
// Shared opcodes, wide arithmetic type and range-check helper for the second-stage ALU.
// Latency: none (package only).
// Backpressure: none (package only).
package alu_child_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_MUL  = 3'b001;
  localparam logic [OP_W-1:0] OP_SGE  = 3'b010;
  localparam logic [OP_W-1:0] OP_MAC  = 3'b011;
  localparam logic [OP_W-1:0] OP_RELU = 3'b100;
  localparam logic [OP_W-1:0] OP_ACLR = 3'b101;
  localparam logic [OP_W-1:0] OP_RSVD = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

  // Largest supported NBITS; the wide type holds any 2*NBITS+1 intermediate.
  localparam int MAX_NBITS = 64;
  localparam int WIDE_W    = 2 * MAX_NBITS + 1;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [1:0] {
    CLAMP_NONE = 2'b00,
    CLAMP_HI   = 2'b01,
    CLAMP_LO   = 2'b10
  } clamp_e;

  // Classifies an exact result against the nbits-wide signed or unsigned range.
  function automatic clamp_e range_check(input wide_t full, input int nbits,
                                         input logic is_signed);
    wide_t hi;
    wide_t lo;
    if (is_signed) begin
      hi = (wide_t'(1) <<< (nbits - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (nbits - 1));
    end else begin
      hi = (wide_t'(1) <<< nbits) - wide_t'(1);
      lo = '0;
    end
    if (full > hi) return CLAMP_HI;
    if (full < lo) return CLAMP_LO;
    return CLAMP_NONE;
  endfunction

endpackage

// File: rtl/alu_child_mul.sv
// Registered multiplier plus side-band shift register carrying valid/op/operands.
// Latency: DEPTH cycles (DEPTH may be 0, in which case the block is pure wiring).
// Backpressure: en_i low freezes every stage; bubbles ride through as vld=0.
module alu_child_mul
  import alu_child_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int DEPTH     = 1,
  parameter bit IS_SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en_i,
  input  logic               vld_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic [NBITS-1:0]   a_i,
  input  logic [NBITS-1:0]   c_i,
  output logic               vld_o,
  output logic [OP_W-1:0]    op_o,
  output logic [NBITS-1:0]   a_o,
  output logic [NBITS-1:0]   c_o,
  output logic [2*NBITS-1:0] prod_o
);

  localparam int PW = 2 * NBITS;

  logic [PW-1:0] a_x;
  logic [PW-1:0] c_x;
  logic [PW-1:0] prod_d;

  // Extend both operands to full product width so the low PW bits are the exact product.
  always_comb begin
    a_x    = {{NBITS{IS_SIGNED & a_i[NBITS-1]}}, a_i};
    c_x    = {{NBITS{IS_SIGNED & c_i[NBITS-1]}}, c_i};
    prod_d = a_x * c_x;
  end

  generate
    if (DEPTH == 0) begin : g_comb
      assign vld_o  = vld_i;
      assign op_o   = op_i;
      assign a_o    = a_i;
      assign c_o    = c_i;
      assign prod_o = prod_d;
    end else begin : g_pipe
      logic [DEPTH-1:0] vld_q;
      logic [OP_W-1:0]  op_q   [DEPTH];
      logic [NBITS-1:0] a_q    [DEPTH];
      logic [NBITS-1:0] c_q    [DEPTH];
      logic [PW-1:0]    prod_q [DEPTH];

      // Advance every stage together when the consumer side is not stalled.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            op_q[i]   <= '0;
            a_q[i]    <= '0;
            c_q[i]    <= '0;
            prod_q[i] <= '0;
          end
        end else if (en_i) begin
          vld_q[0]  <= vld_i;
          op_q[0]   <= op_i;
          a_q[0]    <= a_i;
          c_q[0]    <= c_i;
          prod_q[0] <= prod_d;
          for (int i = 1; i < DEPTH; i++) begin
            vld_q[i]  <= vld_q[i-1];
            op_q[i]   <= op_q[i-1];
            a_q[i]    <= a_q[i-1];
            c_q[i]    <= c_q[i-1];
            prod_q[i] <= prod_q[i-1];
          end
        end
      end

      assign vld_o  = vld_q[DEPTH-1];
      assign op_o   = op_q[DEPTH-1];
      assign a_o    = a_q[DEPTH-1];
      assign c_o    = c_q[DEPTH-1];
      assign prod_o = prod_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/alu_child_pipe.sv
// Second-stage ALU: add/mul/compare/MAC/ReLU/acc-clear/pass with optional saturation.
// Latency: MUL_STAGES cycles for every opcode (MUL_STAGES-1 in alu_child_mul + output register).
// Backpressure: in_ready = !(out_valid && !out_ready); a stall freezes all stages and the accumulator.
module alu_child_pipe
  import alu_child_pkg::*;
#(
  parameter int NBITS      = 32,
  parameter int MUL_STAGES = 2,
  parameter int SIGNED     = 1,
  parameter int SAT        = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] alu_result1,
  input  logic [NBITS-1:0] src_c,
  input  logic [2:0]       alu2_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] alu_result,
  output logic             ovf,
  output logic [NBITS-1:0] acc_value
);

  localparam bit IS_S   = (SIGNED != 0);
  localparam bit SAT_EN = (SAT != 0);
  localparam int PW     = 2 * NBITS;

  logic             out_valid_q;
  logic             ovf_q;
  logic [NBITS-1:0] result_q;
  logic [NBITS-1:0] acc_q;

  logic             ovf_d;
  logic [NBITS-1:0] result_d;
  logic [NBITS-1:0] acc_d;

  logic             adv;
  logic             t_vld;
  logic [OP_W-1:0]  t_op;
  logic [NBITS-1:0] t_a;
  logic [NBITS-1:0] t_c;
  logic [PW-1:0]    t_prod;

  wide_t w_a;
  wide_t w_c;
  wide_t w_acc;
  wide_t w_prod;

  // The only stall source is a held result the consumer has not taken.
  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv;

  alu_child_mul #(
    .NBITS    (NBITS),
    .DEPTH    (MUL_STAGES - 1),
    .IS_SIGNED(IS_S)
  ) u_mul (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (adv),
    .vld_i  (in_valid && adv),
    .op_i   (alu2_control),
    .a_i    (alu_result1),
    .c_i    (src_c),
    .vld_o  (t_vld),
    .op_o   (t_op),
    .a_o    (t_a),
    .c_o    (t_c),
    .prod_o (t_prod)
  );

  function automatic wide_t widen_n(input logic [NBITS-1:0] x);
    return wide_t'({{(WIDE_W-NBITS){IS_S & x[NBITS-1]}}, x});
  endfunction

  function automatic wide_t widen_p(input logic [PW-1:0] x);
    return wide_t'({{(WIDE_W-PW){IS_S & x[PW-1]}}, x});
  endfunction

  // Returns {overflow, value}; the value is clamped only when saturation is enabled.
  function automatic logic [NBITS:0] saturate(input wide_t full);
    clamp_e           cl;
    logic [NBITS-1:0] v;
    cl = range_check(full, NBITS, IS_S);
    v  = full[NBITS-1:0];
    if (SAT_EN && cl == CLAMP_HI) begin
      v = IS_S ? {1'b0, {(NBITS-1){1'b1}}} : {NBITS{1'b1}};
    end else if (SAT_EN && cl == CLAMP_LO) begin
      v = IS_S ? {1'b1, {(NBITS-1){1'b0}}} : {NBITS{1'b0}};
    end
    return {cl != CLAMP_NONE, v};
  endfunction

  // Final-stage result: exact wide arithmetic, then range check / clamp.
  always_comb begin
    w_a      = widen_n(t_a);
    w_c      = widen_n(t_c);
    w_acc    = widen_n(acc_q);
    w_prod   = widen_p(t_prod);
    result_d = '0;
    ovf_d    = 1'b0;
    acc_d    = acc_q;
    case (t_op)
      OP_ADD:  {ovf_d, result_d} = saturate(w_a + w_c);
      OP_MUL:  {ovf_d, result_d} = saturate(w_prod);
      OP_SGE:  result_d = {{(NBITS-1){1'b0}}, (w_a >= w_c)};
      OP_MAC: begin
        {ovf_d, result_d} = saturate(w_acc + w_prod);
        acc_d = result_d;
      end
      OP_RELU: result_d = (IS_S && t_a[NBITS-1]) ? '0 : t_a;
      OP_ACLR: begin
        result_d = acc_q;
        acc_d    = '0;
      end
      OP_PASS: result_d = t_a;
      default: result_d = '0;
    endcase
  end

  // Output register; the accumulator moves only here so back-to-back MACs chain in order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else if (adv) begin
      out_valid_q <= t_vld;
      if (t_vld) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        acc_q    <= acc_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign ovf        = ovf_q;
  assign acc_value  = acc_q;

endmodule

// File: tb/tb_alu_child_pipe.sv
// Bench for alu_child_pipe: signed/saturating and unsigned/wrapping instances share one stimulus.
// Latency: expects results MUL_STAGES (=2) cycles after acceptance.
// Backpressure: random and directed out_ready stalls; results checked through in-order scoreboards.
module tb_alu_child_pipe;
  import alu_child_pkg::*;

  localparam int L = 2;

  typedef logic signed [127:0] big_t;
  typedef struct {
    logic [31:0] r;
    logic        o;
    logic [31:0] acc;
    bit          lit;
    logic [31:0] lr;
    logic        lo;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, in_valid, out_ready;
  logic [31:0] alu_result1, src_c;
  logic [2:0]  alu2_control;
  logic        in_ready, out_valid, ovf;
  logic [31:0] alu_result, acc_value;
  logic        in_ready_u, out_valid_u, ovf_u;
  logic [31:0] alu_result_u, acc_value_u;

  alu_child_pipe #(.NBITS(32), .MUL_STAGES(L), .SIGNED(1), .SAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result1(alu_result1), .src_c(src_c), .alu2_control(alu2_control),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .ovf(ovf), .acc_value(acc_value)
  );

  alu_child_pipe #(.NBITS(32), .MUL_STAGES(L), .SIGNED(0), .SAT(0)) dut_u (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .alu_result1(alu_result1), .src_c(src_c), .alu2_control(alu2_control),
    .out_valid(out_valid_u), .out_ready(out_ready), .alu_result(alu_result_u),
    .ovf(ovf_u), .acc_value(acc_value_u)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact arithmetic on 128-bit integers, then range rules for the given mode.
  function automatic big_t big(input logic [31:0] x, input bit sg);
    return $signed({{96{sg & x[31]}}, x});
  endfunction

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] c,
                       input bit sg, input bit sat, inout logic [31:0] acc,
                       output logic [31:0] r, output logic o);
    big_t va, vc, full, hi, lo;
    bit   arith;
    va    = big(a, sg);
    vc    = big(c, sg);
    hi    = sg ? 128'sh7FFF_FFFF : 128'shFFFF_FFFF;
    lo    = sg ? -128'sh8000_0000 : 128'sh0;
    r     = 32'h0;
    o     = 1'b0;
    arith = 1'b0;
    full  = '0;
    case (op)
      3'd0: begin full = va + vc; arith = 1'b1; end
      3'd1: begin full = va * vc; arith = 1'b1; end
      3'd2: r = (va >= vc) ? 32'd1 : 32'd0;
      3'd3: begin full = big(acc, sg) + va * vc; arith = 1'b1; end
      3'd4: r = (sg && va < 0) ? 32'd0 : a;
      3'd5: begin r = acc; acc = 32'h0; end
      3'd7: r = a;
      default: r = 32'h0;
    endcase
    if (arith) begin
      o = (full > hi) || (full < lo);
      if (sat && full > hi)      r = hi[31:0];
      else if (sat && full < lo) r = lo[31:0];
      else                       r = full[31:0];
      if (op == 3'd3) acc = r;
    end
  endtask

  exp_t        qs[$];
  exp_t        qu[$];
  logic [31:0] acc_s_m = 32'h0;
  logic [31:0] acc_u_m = 32'h0;
  bit          lit_s_en = 0, lit_u_en = 0;
  logic [31:0] lit_s_r, lit_u_r;
  logic        lit_s_o, lit_u_o;

  // Monitor: scoreboard pops on output handshake, pushes on input handshake, hold checks on stall.
  bit          prev_stall = 0;
  logic [31:0] prev_res, prev_acc;
  logic        prev_ovf;
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] r;
    logic        o;
    if (!reset_n) begin
      qs.delete();
      qu.delete();
      acc_s_m    = 32'h0;
      acc_u_m    = 32'h0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_res", alu_result, prev_res);
        chk("hold_ovf", ovf, prev_ovf);
        chk("hold_acc", acc_value, prev_acc);
      end
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      chk("in_ready_rule_u", in_ready_u, !(out_valid_u && !out_ready));
      if (out_valid && out_ready) begin
        if (qs.size() == 0) chk("s_spurious", out_valid, 0);
        else begin
          e = qs.pop_front();
          chk("s_res", alu_result, e.r);
          chk("s_ovf", ovf, e.o);
          chk("s_acc", acc_value, e.acc);
          if (e.lit) begin
            chk("s_lit_res", alu_result, e.lr);
            chk("s_lit_ovf", ovf, e.lo);
          end
        end
      end
      if (out_valid_u && out_ready) begin
        if (qu.size() == 0) chk("u_spurious", out_valid_u, 0);
        else begin
          e = qu.pop_front();
          chk("u_res", alu_result_u, e.r);
          chk("u_ovf", ovf_u, e.o);
          chk("u_acc", acc_value_u, e.acc);
          if (e.lit) begin
            chk("u_lit_res", alu_result_u, e.lr);
            chk("u_lit_ovf", ovf_u, e.lo);
          end
        end
      end
      if (in_valid && in_ready) begin
        model(alu2_control, alu_result1, src_c, 1'b1, 1'b1, acc_s_m, r, o);
        e.r = r; e.o = o; e.acc = acc_s_m; e.lit = lit_s_en; e.lr = lit_s_r; e.lo = lit_s_o;
        qs.push_back(e);
      end
      if (in_valid && in_ready_u) begin
        model(alu2_control, alu_result1, src_c, 1'b0, 1'b0, acc_u_m, r, o);
        e.r = r; e.o = o; e.acc = acc_u_m; e.lit = lit_u_en; e.lr = lit_u_r; e.lo = lit_u_o;
        qu.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = alu_result;
      prev_ovf   = ovf;
      prev_acc   = acc_value;
    end
  end

  // Drivers: always entered and left at posedge+1.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] c);
    int n;
    n = 0;
    in_valid = 1'b1; alu2_control = op; alu_result1 = a; src_c = c;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge clk); #1;
    lit_s_en = 0;
    lit_u_en = 0;
  endtask

  task automatic send_s(input logic [2:0] op, input logic [31:0] a, input logic [31:0] c,
                        input logic [31:0] r, input logic o);
    lit_s_en = 1; lit_s_r = r; lit_s_o = o;
    send(op, a, c);
  endtask

  task automatic send_u(input logic [2:0] op, input logic [31:0] a, input logic [31:0] c,
                        input logic [31:0] r, input logic o);
    lit_u_en = 1; lit_u_r = r; lit_u_o = o;
    send(op, a, c);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((qs.size() != 0 || qu.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_s", qs.size(), 0);
    chk("drain_u", qu.size(), 0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 4))
      0: return $urandom_range(0, 20);
      1: return 32'h0 - $urandom_range(0, 20);
      2: case ($urandom_range(0, 3))
           0: return 32'h7FFF_FFFF;
           1: return 32'h8000_0000;
           2: return 32'hFFFF_FFFF;
           default: return 32'h0001_0000;
         endcase
      default: return $urandom();
    endcase
  endfunction

  bit rnd_done = 0;

  initial begin
    int n;
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_result1 = '0; src_c = '0; alu2_control = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", alu_result, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_acc", acc_value, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid_u", out_valid_u, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Latency of a lone beat.
    send_s(OP_PASS, 32'h55, 32'h0, 32'h55, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk("latency", n, L);
    @(posedge clk); #1;

    // Directed opcode vectors.
    send_s(OP_ADD, 32'h7FFF_FFF0, 32'h20, 32'h7FFF_FFFF, 1'b1);
    send_s(OP_ADD, 32'd5, 32'hFFFF_FFFD, 32'd2, 1'b0);
    send_s(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h7FFF_FFFF, 1'b1);
    send_s(OP_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0);
    send_s(OP_SGE, 32'hFFFF_FFFE, 32'd0, 32'd0, 1'b0);
    send_s(OP_SGE, 32'd7, 32'd7, 32'd1, 1'b0);
    send_s(OP_RELU, 32'hFFFF_FFF7, 32'd0, 32'd0, 1'b0);
    send_s(OP_RELU, 32'd9, 32'd0, 32'd9, 1'b0);
    send_s(OP_RSVD, 32'h1234, 32'd0, 32'd0, 1'b0);
    send_s(OP_PASS, 32'h1234, 32'd0, 32'h1234, 1'b0);
    send_u(OP_SGE, 32'hFFFF_FFFE, 32'd0, 32'd1, 1'b0);
    send_u(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);

    // MAC chain with clear immediately followed by MAC.
    send_s(OP_MAC, 32'd1, 32'd1, 32'd1, 1'b0);
    send_s(OP_ACLR, 32'd0, 32'd0, 32'd1, 1'b0);
    send_s(OP_MAC, 32'd3, 32'd4, 32'd12, 1'b0);
    send_s(OP_MAC, 32'd5, 32'd6, 32'd42, 1'b0);
    send_s(OP_MAC, 32'hFFFF_FFFE, 32'd10, 32'd22, 1'b0);
    drain();
    chk("mac_acc", acc_value, 32'd22);
    chk("mac_acc_u", acc_value_u, 32'd22);
    send_s(OP_ACLR, 32'd0, 32'd0, 32'd22, 1'b0);
    drain();
    chk("clr_acc", acc_value, 32'd0);

    // Backpressure: four adds, consumer stalls for three cycles after the first result.
    fork
      begin
        for (int i = 1; i <= 4; i++) send(OP_ADD, i, 100 * i);
        in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp_first_vld", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_acc", acc_value, acc_s_m);

    // Random traffic with random consumer stalls.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) idle();
          send(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
        end
        in_valid = 1'b0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with MACs in flight.
    send(OP_MAC, 32'd3, 32'd4);
    send(OP_MAC, 32'd5, 32'd6);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_acc", acc_value, 0);
    chk("midrst_result", alu_result, 0);
    chk("midrst_acc_u", acc_value_u, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_stale", out_valid, 0);
      chk("midrst_no_stale_u", out_valid_u, 0);
    end
    @(posedge clk); #1;
    send_s(OP_MAC, 32'd2, 32'd3, 32'd6, 1'b0);
    drain();
    chk("post_rst_acc", acc_value, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
